// File: rtl/piso_pkg.sv
// Shared types and frame-geometry helpers for the piso_tx serial transmitter.
// Optional parity bit is enabled by defining PISO_TX_PARITY_EN.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

`ifdef PISO_TX_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int flen(input int width);
    return PARITY_EN ? width + 1 : width;
  endfunction

  // Never below one bit so a bad WIDTH reaches the explicit elaboration check.
  function automatic int cnt_w(input int width);
    return (flen(width) > 2) ? $clog2(flen(width)) : 1;
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Frame bit counter: clear on accept, saturating increment, last-bit flags.
// Exposes the last data-bit flag only when PISO_TX_PARITY_EN is defined.
module piso_bit_cnt #(
  parameter int FLEN = 4,
  parameter int CW   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
`ifdef PISO_TX_PARITY_EN
  output logic data_last,
`endif
  output logic is_last,
  output logic last_next
);

  localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !is_last) begin
      cnt_d = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_d;
    end
  end

  assign is_last   = (cnt == LAST);
  assign last_next = (cnt_d == LAST);

`ifdef PISO_TX_PARITY_EN
  assign data_last = (cnt == CW'(FLEN - 2));
`endif

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load and frame flags.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_last
);

  localparam int FLEN = flen(WIDTH);
  localparam int CW   = cnt_w(WIDTH);

  if (WIDTH < 2) begin : g_width_check
    $error("piso_tx: WIDTH must be at least 2");
  end

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] shreg;
  logic             accept;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             adv;
  logic             is_last;
  logic             last_next;
`ifdef PISO_TX_PARITY_EN
  logic             data_last;
  logic             to_par;
  logic             par;
`endif

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic next_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-2] : w[1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  piso_bit_cnt #(
    .FLEN(FLEN),
    .CW  (CW)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
`ifdef PISO_TX_PARITY_EN
    .data_last(data_last),
`endif
    .is_last  (is_last),
    .last_next(last_next)
  );

  // Ready in IDLE and on the final frame bit, which enables gapless frames.
  assign load_ready = (state == IDLE) || is_last;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    adv     = 1'b0;
`ifdef PISO_TX_PARITY_EN
    to_par  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
        end
      end
      SHIFT, PARITY: begin
        if (is_last) begin
          cnt_clr = 1'b1;
          state_d = accept ? SHIFT : IDLE;
        end else begin
          cnt_inc = 1'b1;
`ifdef PISO_TX_PARITY_EN
          if (data_last) begin
            state_d = PARITY;
            to_par  = 1'b1;
          end else begin
            adv = 1'b1;
          end
`else
          adv = 1'b1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      sout_valid  <= (state_d != IDLE);
      frame_start <= accept;
      frame_last  <= (state_d != IDLE) && last_next;
      if (accept) begin
        shreg <= din;
        sout  <= first_bit(din);
`ifdef PISO_TX_PARITY_EN
        par   <= ^din;
`endif
      end else if (adv) begin
        shreg <= shift_word(shreg);
        sout  <= next_bit(shreg);
`ifdef PISO_TX_PARITY_EN
      end else if (to_par) begin
        sout  <= par;
`endif
      end else if (state_d == IDLE) begin
        sout  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: LSB/MSB order, back-to-back, din hold, reset, parity.
module tb_piso_tx;

  localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         lv0, lv1;
  logic         lr0, so0, sv0, fs0, fl0;
  logic         lr1, so1, sv1, fs1, fl1;
  logic         sel;
  logic [4:0]   obs;
  logic [4:0]   sb[$];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(lv0), .load_ready(lr0),
    .sout(so0), .sout_valid(sv0), .frame_start(fs0), .frame_last(fl0)
  );

  piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .load_valid(lv1), .load_ready(lr1),
    .sout(so1), .sout_valid(sv1), .frame_start(fs1), .frame_last(fl1)
  );

  // Observed vector: {sout_valid, sout, frame_start, frame_last, load_ready}
  assign obs = sel ? {sv1, so1, fs1, fl1, lr1} : {sv0, so0, fs0, fl0, lr0};

  function automatic void push_frame(input logic [W-1:0] w, input bit msb);
    logic b;
    for (int i = 0; i < FL; i++) begin
      if (i < W) b = msb ? w[W-1-i] : w[i];
      else       b = ^w;
      sb.push_back({1'b1, b, (i == 0), (i == FL - 1), (i == FL - 1)});
    end
  endfunction

  function automatic void push_idle();
    sb.push_back(5'b00001);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; lv0 = 1'b0; lv1 = 1'b0; din = '0; sel = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sv0, so0, fs0, fl0, lr0} !== 5'b00001) begin
      errors++; $display("FAIL reset_dut0 got %b exp %b", {sv0, so0, fs0, fl0, lr0}, 5'b00001);
    end
    checks++;
    if ({sv1, so1, fs1, fl1, lr1} !== 5'b00001) begin
      errors++; $display("FAIL reset_dut1 got %b exp %b", {sv1, so1, fs1, fl1, lr1}, 5'b00001);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 5'b00001) begin
      errors++; $display("FAIL reset_release got %b exp %b", obs, 5'b00001);
    end
  endtask

  task automatic test_lsb_first();
    logic [4:0] e;
    int c = 0;
    sel = 1'b0;
    push_frame(4'b1001, 1'b0); push_idle();
    @(negedge clk); din = 4'b1001; lv0 = 1'b1;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front(); c++; checks++;
      if (obs !== e) begin
        errors++; $display("FAIL lsb_first cyc %0d got %b exp %b", c, obs, e);
      end
      if (c == 1) lv0 = 1'b0;
    end
  endtask

  task automatic test_msb_first();
    logic [4:0] e;
    int c = 0;
    sel = 1'b1;
    push_frame(4'b1100, 1'b1); push_idle();
    @(negedge clk); din = 4'b1100; lv1 = 1'b1;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front(); c++; checks++;
      if (obs !== e) begin
        errors++; $display("FAIL msb_first cyc %0d got %b exp %b", c, obs, e);
      end
      if (c == 1) lv1 = 1'b0;
    end
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    int c = 0;
    sel = 1'b0;
    push_frame(4'b1010, 1'b0); push_frame(4'b0110, 1'b0); push_idle();
    @(negedge clk); din = 4'b1010; lv0 = 1'b1;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front(); c++; checks++;
      if (obs !== e) begin
        errors++; $display("FAIL back_to_back cyc %0d got %b exp %b", c, obs, e);
      end
      if (c == 1) din = 4'b0110;
      if (c == FL + 1) lv0 = 1'b0;
    end
  endtask

  task automatic test_hold_din();
    logic [4:0] e;
    int c = 0;
    sel = 1'b0;
    push_frame(4'b0001, 1'b0); push_frame(4'b1111, 1'b0); push_idle();
    @(negedge clk); din = 4'b0001; lv0 = 1'b1;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front(); c++; checks++;
      if (obs !== e) begin
        errors++; $display("FAIL hold_din cyc %0d got %b exp %b", c, obs, e);
      end
      if (c == 2) din = 4'b1111;
      if (c == FL + 1) lv0 = 1'b0;
    end
  endtask

  task automatic test_reset_midframe();
    logic [4:0] e;
    int c = 0;
    sel = 1'b0;
    push_frame(4'b0101, 1'b0);
    @(negedge clk); din = 4'b0101; lv0 = 1'b1;
    repeat (2) begin
      @(negedge clk);
      e = sb.pop_front(); c++; checks++;
      if (obs !== e) begin
        errors++; $display("FAIL rst_mid_pre cyc %0d got %b exp %b", c, obs, e);
      end
      lv0 = 1'b0;
    end
    sb.delete();
    #2 rst_n = 1'b0;
    #1 checks++;
    if (obs !== 5'b00001) begin
      errors++; $display("FAIL rst_mid_async got %b exp %b", obs, 5'b00001);
    end
    @(negedge clk);
    checks++;
    if (obs !== 5'b00001) begin
      errors++; $display("FAIL rst_mid_held got %b exp %b", obs, 5'b00001);
    end
    rst_n = 1'b1;
    c = 0;
    push_frame(4'b0011, 1'b0); push_idle();
    @(negedge clk); din = 4'b0011; lv0 = 1'b1;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front(); c++; checks++;
      if (obs !== e) begin
        errors++; $display("FAIL rst_mid_post cyc %0d got %b exp %b", c, obs, e);
      end
      if (c == 1) lv0 = 1'b0;
    end
  endtask

`ifdef PISO_TX_PARITY_EN
  task automatic test_parity();
    logic [4:0] e;
    logic [W-1:0] words [2];
    words[0] = 4'b0111;
    words[1] = 4'b0000;
    sel = 1'b0;
    for (int k = 0; k < 2; k++) begin
      int c = 0;
      push_frame(words[k], 1'b0); push_idle();
      @(negedge clk); din = words[k]; lv0 = 1'b1;
      while (sb.size() > 0) begin
        @(negedge clk);
        e = sb.pop_front(); c++; checks++;
        if (obs !== e) begin
          errors++; $display("FAIL parity w%0d cyc %0d got %b exp %b", k, c, obs, e);
        end
        if (c == 1) lv0 = 1'b0;
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_hold_din();
    test_reset_midframe();
`ifdef PISO_TX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
